// File: rtl/led_frame_rd_ctrl.sv
// led_frame_rd_ctrl: reads zone-brightness bytes from a FIFO, packs them into
// one frame word, hands it to the LED driver with valid/ready, then idles for
// an inter-frame gap.
// Ports:
//   rd_clk, rst_n            clock, async active-low reset
//   enable                   start/continue frame reads
//   fifo_empty, fifo_dout    FIFO status and read data (1-cycle read latency)
//   fifo_rd_en               FIFO read strobe
//   frame_data, frame_valid  assembled frame and its valid flag
//   frame_ready              driver accepts the frame
//   byte_cnt, busy           bytes captured in this frame; not idle
//   frame_cnt                accepted frames (wrapping)
//   err_timeout              starvation-abort pulse
// Optional feature: define LED_RD_TIMEOUT_EN to abort a frame starved mid-fill.
module led_frame_rd_ctrl #(
    parameter int BYTES_PER_FRAME = 40,
    parameter int CNT_W           = 6,
    parameter int GAP_CYCLES      = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                         rd_clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         fifo_empty,
    input  logic [7:0]                   fifo_dout,
    output logic                         fifo_rd_en,
    output logic [8*BYTES_PER_FRAME-1:0] frame_data,
    output logic                         frame_valid,
    input  logic                         frame_ready,
    output logic [CNT_W-1:0]             byte_cnt,
    output logic                         busy,
    output logic [15:0]                  frame_cnt,
    output logic                         err_timeout
);

    localparam logic [CNT_W-1:0] BPF  = CNT_W'(BYTES_PER_FRAME);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES_PER_FRAME - 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST =
        GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PRESENT,
        GAP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] issued;
    logic             rd_pend;
    logic [GAP_W-1:0] gap_cnt;
    logic             last_cap;
    logic             accept;
    logic             gap_done;
    logic             abort;

    // rd_pend marks that fifo_dout carries a byte this cycle
    assign last_cap    = rd_pend && (byte_cnt == LAST);
    assign frame_valid = (state == PRESENT);
    assign accept      = frame_valid && frame_ready;
    assign gap_done    = (gap_cnt == GAP_LAST);
    assign busy        = (state != IDLE);

`ifdef LED_RD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] starve;
    logic            starving;

    // an empty FIFO implies no read this cycle, so leaving the
    // starving condition is what clears the counter on a read
    assign starving = (state == FILL) && (byte_cnt != '0) && fifo_empty;
    assign abort    = starving && (starve == TO_LAST);

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            starve      <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= abort;
            if (starving && !abort)
                starve <= starve + 1'b1;
            else
                starve <= '0;
        end
    end
`else
    assign abort       = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable)
                    state_nxt = FILL;
            end
            FILL: begin
                // issued caps reads, so no over-read even if empty drops
                // in the same cycle the last byte lands
                fifo_rd_en = !fifo_empty && (issued < BPF);
                if (abort)
                    state_nxt = enable ? FILL : IDLE;
                else if (last_cap)
                    state_nxt = PRESENT;
            end
            PRESENT: begin
                if (accept) begin
                    if (GAP_CYCLES > 0)
                        state_nxt = GAP;
                    else
                        state_nxt = enable ? FILL : IDLE;
                end
            end
            GAP: begin
                if (gap_done)
                    state_nxt = enable ? FILL : IDLE;
            end
        endcase
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            issued     <= '0;
            rd_pend    <= 1'b0;
            byte_cnt   <= '0;
            frame_data <= '0;
            frame_cnt  <= '0;
            gap_cnt    <= '0;
        end else begin
            rd_pend <= fifo_rd_en;
            if (fifo_rd_en)
                issued <= issued + 1'b1;
            if (rd_pend) begin
                frame_data[8*byte_cnt +: 8] <= fifo_dout;
                byte_cnt <= byte_cnt + 1'b1;
            end
            if (abort) begin
                issued   <= '0;
                byte_cnt <= '0;
                rd_pend  <= 1'b0;
            end
            if (accept) begin
                frame_cnt <= frame_cnt + 1'b1;
                byte_cnt  <= '0;
                issued    <= '0;
            end
            if (state == GAP)
                gap_cnt <= gap_cnt + 1'b1;
            else
                gap_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_led_frame_rd_ctrl.sv
// tb_led_frame_rd_ctrl: randomized bench for led_frame_rd_ctrl with a
// behavioural FIFO and a per-cycle reference model of the read scheduler.
module tb_led_frame_rd_ctrl;

    localparam int BPF = 40;
    localparam int GAP = 16;
    localparam int TO  = 1024;
    localparam int W   = 8 * BPF;

    localparam int PH_IDLE = 0;
    localparam int PH_FILL = 1;
    localparam int PH_PRES = 2;
    localparam int PH_GAP  = 3;

    logic         rd_clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic         fifo_empty = 1'b1;
    logic [7:0]   fifo_dout = 8'h00;
    logic         fifo_rd_en;
    logic [W-1:0] frame_data;
    logic         frame_valid;
    logic         frame_ready = 1'b0;
    logic [5:0]   byte_cnt;
    logic         busy;
    logic [15:0]  frame_cnt;
    logic         err_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    led_frame_rd_ctrl dut (
        .rd_clk      (rd_clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .fifo_empty  (fifo_empty),
        .fifo_dout   (fifo_dout),
        .fifo_rd_en  (fifo_rd_en),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .byte_cnt    (byte_cnt),
        .busy        (busy),
        .frame_cnt   (frame_cnt),
        .err_timeout (err_timeout)
    );

    always #5 rd_clk = ~rd_clk;

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic expire(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    // ---------------- behavioural FIFO ----------------
    logic [7:0] q[$];
    int         emp_mode = 0;
    int         fcyc = 0;
    bit         rd_seen = 0;

    always @(negedge rd_clk) rd_seen = fifo_rd_en;

    always @(posedge rd_clk) begin
        bit extra;
        #1;
        fcyc++;
        if (rd_seen) begin
            if (q.size() > 0) begin
                fifo_dout = q.pop_front();
            end else begin
                n_cmp++;
                n_bad++;
                $display("FAIL overread: got read want none");
            end
        end
        case (emp_mode)
            1: extra = (fcyc % 2) == 1;
            2: extra = ($urandom_range(0, 2) == 0);
            3: extra = 1'b1;
            default: extra = 1'b0;
        endcase
        fifo_empty = (q.size() == 0) || extra;
    end

    // ---------------- reference model + compare ----------------
    int           m_ph, m_bytes, m_issued, m_gap_left, m_starve;
    bit           m_pend, m_err;
    int           m_fc;
    logic [W-1:0] m_frame;

    int cyc = 0;
    int first_rd, last_rd, rd_in_frame, fv_cyc, acc_cyc, next_rd;
    int idle_cyc, rd_empty, err_pulses;
    bit wait_next, fv_prev, busy_prev;

    task automatic model_reset();
        m_ph = PH_IDLE;
        m_bytes = 0;
        m_issued = 0;
        m_gap_left = 0;
        m_starve = 0;
        m_pend = 0;
        m_err = 0;
        m_fc = 0;
        m_frame = '0;
    endtask

    initial begin
        model_reset();
        rd_in_frame = 0;
        rd_empty = 0;
        err_pulses = 0;
        wait_next = 0;
    end

    always @(negedge rd_clk) begin
        bit exp_rd;
        bit abort;
        cyc++;
        if (!rst_n) begin
            model_reset();
            rd_in_frame = 0;
        end
        exp_rd = (m_ph == PH_FILL) && !fifo_empty && (m_issued < BPF);
        chk("rd_en", W'(fifo_rd_en), W'(exp_rd));
        chk("frame_valid", W'(frame_valid), W'(m_ph == PH_PRES));
        chk("busy", W'(busy), W'(m_ph != PH_IDLE));
        chk("byte_cnt", W'(byte_cnt), W'(m_bytes));
        chk("frame_cnt", W'(frame_cnt), W'(m_fc[15:0]));
        chk("err_timeout", W'(err_timeout), W'(m_err));
        chk("frame_data", frame_data, m_frame);

        // observed-timing statistics taken from the DUT itself
        if (err_timeout) begin
            err_pulses++;
            rd_in_frame = 0;
        end
        if (fifo_rd_en && fifo_empty) rd_empty++;
        if (fifo_rd_en) begin
            if (rd_in_frame == 0) first_rd = cyc;
            last_rd = cyc;
            rd_in_frame++;
            if (wait_next) begin
                next_rd = cyc;
                wait_next = 0;
            end
        end
        if (frame_valid && !fv_prev) fv_cyc = cyc;
        if (!busy && busy_prev) idle_cyc = cyc;
        if (frame_valid && frame_ready) begin
            acc_cyc = cyc;
            rd_in_frame = 0;
            wait_next = 1;
        end
        fv_prev = frame_valid;
        busy_prev = busy;

        // advance the model across the coming clock edge
        if (rst_n) begin
            m_err = 0;
            case (m_ph)
                PH_IDLE: if (enable) m_ph = PH_FILL;
                PH_FILL: begin
                    abort = 0;
`ifdef LED_RD_TIMEOUT_EN
                    if (m_bytes > 0 && fifo_empty) m_starve++;
                    else m_starve = 0;
                    abort = (m_starve == TO);
`endif
                    if (abort) begin
                        m_bytes = 0;
                        m_issued = 0;
                        m_pend = 0;
                        m_starve = 0;
                        m_err = 1;
                        m_ph = enable ? PH_FILL : PH_IDLE;
                    end else begin
                        if (m_pend) begin
                            m_frame[8*m_bytes +: 8] = fifo_dout;
                            m_bytes++;
                        end
                        if (exp_rd) m_issued++;
                        m_pend = exp_rd;
                        if (m_bytes == BPF) m_ph = PH_PRES;
                    end
                end
                PH_PRES: begin
                    if (frame_ready) begin
                        m_fc = (m_fc + 1) % 65536;
                        m_bytes = 0;
                        m_issued = 0;
                        m_gap_left = GAP;
                        m_ph = PH_GAP;
                    end
                end
                default: begin
                    m_gap_left--;
                    if (m_gap_left == 0)
                        m_ph = enable ? PH_FILL : PH_IDLE;
                end
            endcase
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0]   pb[BPF];
    logic [W-1:0] pexp;

    task automatic go();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic push_frame(input bit ramp);
        for (int i = 0; i < BPF; i++) begin
            pb[i] = ramp ? 8'(i + 1) : 8'($urandom_range(0, 255));
            q.push_back(pb[i]);
            pexp[8*i +: 8] = pb[i];
        end
    endtask

    task automatic wait_valid(input string nm);
        bit ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge rd_clk);
            ok = frame_valid;
        end
        if (!ok) expire(nm);
    endtask

    task automatic wait_bytes(input int n, input string nm);
        bit ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge rd_clk);
            ok = (byte_cnt >= 6'(n));
        end
        if (!ok) expire(nm);
    endtask

    task automatic wait_idle(input string nm);
        bit ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge rd_clk);
            ok = !busy;
        end
        if (!ok) expire(nm);
    endtask

    task automatic accept_one();
        go();
        frame_ready = 1'b1;
        go();
        frame_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] snap;
        int fc0;
        // reset state
        push_frame(1'b1);
        repeat (3) go();
        @(negedge rd_clk);
        chk("rst_valid", W'(frame_valid), '0);
        chk("rst_data", frame_data, '0);
        chk("rst_rd_en", W'(fifo_rd_en), '0);
        go();
        rst_n = 1'b1;
        enable = 1'b1;

        // 1: ramp frame, consecutive reads, valid latency
        wait_valid("t1_valid");
        go();
        chk("t1_reads", W'(rd_in_frame), W'(BPF));
        chk("t1_consec", W'(last_rd - first_rd), W'(BPF - 1));
        chk("t1_latency", W'(fv_cyc - last_rd), W'(2));
        chk("t1_byte0", W'(frame_data[7:0]), W'(8'h01));
        chk("t1_byte39", W'(frame_data[319:312]), W'(8'h28));
        chk("t1_byte20", W'(frame_data[167:160]), W'(8'h15));

        // 2: hold ready low, stability, accept, gap
        push_frame(1'b0);
        snap = frame_data;
        repeat (50) @(negedge rd_clk);
        chk("t2_valid_held", W'(frame_valid), W'(1));
        chk("t2_data_held", frame_data, snap);
        chk("t2_no_read", W'(fifo_rd_en), '0);
        accept_one();
        @(negedge rd_clk);
        chk("t2_frame_cnt", W'(frame_cnt), W'(1));
        wait_valid("t2_valid");
        go();
        chk("t2_gap", W'(next_rd - acc_cyc), W'(GAP + 1));
        chk("t2_data", frame_data, pexp);

        // 3: empty toggles every other cycle
        emp_mode = 1;
        push_frame(1'b0);
        accept_one();
        wait_valid("t3_valid");
        go();
        chk("t3_reads", W'(rd_in_frame), W'(BPF));
        chk("t3_data", frame_data, pexp);
        chk("t3_rd_empty", W'(rd_empty), '0);

        // 4: enable dropped mid-fill
        emp_mode = 0;
        push_frame(1'b0);
        accept_one();
        wait_bytes(10, "t4_bytes");
        go();
        enable = 1'b0;
        wait_valid("t4_valid");
        go();
        chk("t4_data", frame_data, pexp);
        chk("t4_bytes", W'(byte_cnt), W'(BPF));
        accept_one();
        wait_idle("t4_idle");
        go();
        chk("t4_idle_lat", W'(idle_cyc - acc_cyc), W'(GAP + 1));
        chk("t4_busy", W'(busy), '0);

        // 5: reset pulse mid-frame
        push_frame(1'b0);
        push_frame(1'b0);
        go();
        enable = 1'b1;
        wait_bytes(25, "t5_bytes");
        go();
        rst_n = 1'b0;
        @(negedge rd_clk);
        chk("t5_data", frame_data, '0);
        chk("t5_bytes", W'(byte_cnt), '0);
        chk("t5_fc", W'(frame_cnt), '0);
        chk("t5_busy", W'(busy), '0);
        go();
        rst_n = 1'b1;
        wait_valid("t5_valid");
        go();
        chk("t5_reads", W'(rd_in_frame), W'(BPF));

        // random traffic
        emp_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            go();
            frame_ready = 1'($urandom_range(0, 1));
            enable = ($urandom_range(0, 9) != 0);
            if (q.size() < 50) push_frame(1'b0);
        end
        chk("rand_progress", W'(frame_cnt >= 16'd5), W'(1));
        go();
        emp_mode = 0;
        enable = 1'b0;
        frame_ready = 1'b1;
        wait_idle("drain_idle");
        go();
        frame_ready = 1'b0;
        q.delete();

`ifdef LED_RD_TIMEOUT_EN
        // 6: starvation after 5 bytes
        for (int i = 0; i < 5; i++) q.push_back(8'($urandom_range(0, 255)));
        fc0 = int'(frame_cnt);
        go();
        enable = 1'b1;
        begin
            bit ok = 0;
            for (int i = 0; i < 1500 && !ok; i++) begin
                @(negedge rd_clk);
                ok = err_timeout;
            end
            if (!ok) expire("t6_err");
        end
        repeat (4) go();
        chk("t6_pulses", W'(err_pulses), W'(1));
        chk("t6_bytes", W'(byte_cnt), '0);
        chk("t6_fc", W'(frame_cnt), W'(fc0));
        push_frame(1'b0);
        wait_valid("t6_valid");
        go();
        chk("t6_data", frame_data, pexp);
`else
        fc0 = int'(frame_cnt);
        chk("no_err_pulses", W'(err_pulses), '0);
        chk("fc_stable", W'(frame_cnt), W'(fc0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
